// File: rtl/matrix_scheduler.sv
// Purpose : time-shares a 5x7 LED matrix between three requesters; round-robin
//           arbitration at frame boundaries, one latched frame row-scanned with a
//           blanking gap before every row.
// Latency : grant one cycle after req; first lit row BLANK_TICKS cycles after grant.
// Backpressure: none; requesters hold req level until they are done.
// Ports   : CLOCK_50/reset (sync, active-high); req[2:0] level requests;
//           frame0..frame2 35-bit pixel maps (bit r*7+c = row r, column c);
//           grant one-hot owner, active_id owner index; row/column active-high
//           matrix drive; frame_done pulses on the last lit cycle of each frame.
module matrix_scheduler #(
  parameter int ROW_TICKS       = 10000,
  parameter int BLANK_TICKS     = 50,
  parameter int MIN_HOLD_FRAMES = 2
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [34:0] frame0,
  input  logic [34:0] frame1,
  input  logic [34:0] frame2,
  output logic [2:0]  grant,
  output logic [1:0]  active_id,
  output logic [4:0]  row,
  output logic [6:0]  column,
  output logic        frame_done
);

  localparam int TMAX = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int HW   = $clog2(MIN_HOLD_FRAMES + 1);

  localparam logic [TW-1:0] ROW_LAST   = TW'(ROW_TICKS - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MIN   = HW'(MIN_HOLD_FRAMES);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t      state, state_n;
  logic [TW-1:0] tick, tick_n;
  logic [2:0]  row_idx, row_idx_n;
  logic [HW-1:0] hold, hold_n, hold_inc;
  logic [1:0]  rr_last, rr_n;
  logic [34:0] buffer, buffer_n;
  logic [2:0]  grant_n, others;
  logic [1:0]  active_id_n;
  logic [4:0]  row_n;
  logic [6:0]  column_n;
  logic        frame_done_n;
  logic        latch;

  // First set request scanning last+1, last+2, last+3 (mod 3); zero if none.
  function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [2:0] r);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = '0;
    idx  = last;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (pick == 3'b000 && r[idx]) pick[idx] = 1'b1;
    end
    return pick;
  endfunction

  always_comb begin
    state_n   = state;
    tick_n    = tick + TW'(1);
    row_idx_n = row_idx;
    hold_n    = hold;
    rr_n      = rr_last;
    grant_n   = grant;
    latch     = 1'b0;
    others    = req & ~grant;
    hold_inc  = (hold >= HOLD_MIN) ? hold : hold + HW'(1);

    case (state)
      IDLE: begin
        tick_n = '0;
        if (req != 3'b000) begin
          grant_n   = rr_pick(rr_last, req);
          latch     = 1'b1;
          row_idx_n = '0;
          hold_n    = '0;
          state_n   = BLANK;
        end
      end
      BLANK, SHOW: begin
        if ((req & grant) == 3'b000) begin
          // Owner withdrew: abandon the frame immediately, it goes to the back.
          state_n   = IDLE;
          grant_n   = '0;
          rr_n      = active_id;
          tick_n    = '0;
          row_idx_n = '0;
          hold_n    = '0;
        end else if (state == BLANK) begin
          if (tick == BLANK_LAST) begin
            state_n = SHOW;
            tick_n  = '0;
          end
        end else if (tick == ROW_LAST) begin
          tick_n  = '0;
          state_n = BLANK;
          if (row_idx != 3'd4) begin
            row_idx_n = row_idx + 3'd1;
          end else begin
            // Frame boundary: the only place ownership may change.
            row_idx_n = '0;
            latch     = 1'b1;
            if (hold_inc >= HOLD_MIN && others != 3'b000) begin
              rr_n    = active_id;
              grant_n = rr_pick(active_id, others);
              hold_n  = '0;
            end else begin
              hold_n = hold_inc;
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        tick_n  = '0;
      end
    endcase

    active_id_n = {grant_n[2], grant_n[1]};

    buffer_n = buffer;
    if (latch) begin
      case (grant_n)
        3'b001:  buffer_n = frame0;
        3'b010:  buffer_n = frame1;
        default: buffer_n = frame2;
      endcase
    end

    // Outputs are derived from the next state so they can be registered
    // without adding a cycle of lag to the scan.
    row_n    = '0;
    column_n = '0;
    if (state_n == SHOW) begin
      row_n = 5'b00001 << row_idx_n;
      case (row_idx_n)
        3'd0:    column_n = buffer_n[6:0];
        3'd1:    column_n = buffer_n[13:7];
        3'd2:    column_n = buffer_n[20:14];
        3'd3:    column_n = buffer_n[27:21];
        default: column_n = buffer_n[34:28];
      endcase
    end
    frame_done_n = (state_n == SHOW) && (row_idx_n == 3'd4) && (tick_n == ROW_LAST);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      tick       <= '0;
      row_idx    <= '0;
      hold       <= '0;
      rr_last    <= 2'd2;
      buffer     <= '0;
      grant      <= '0;
      active_id  <= '0;
      row        <= '0;
      column     <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      tick       <= tick_n;
      row_idx    <= row_idx_n;
      hold       <= hold_n;
      rr_last    <= rr_n;
      buffer     <= buffer_n;
      grant      <= grant_n;
      active_id  <= active_id_n;
      row        <= row_n;
      column     <= column_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_matrix_scheduler.sv
// Bench for matrix_scheduler with ROW_TICKS=4, BLANK_TICKS=2, MIN_HOLD_FRAMES=2.
// Expected output cycles are queued when stimulus is applied and compared as
// the design produces them.
module tb_matrix_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [34:0] frame0, frame1, frame2;
  logic [2:0]  grant;
  logic [1:0]  active_id;
  logic [4:0]  row;
  logic [6:0]  column;
  logic        frame_done;

  always #5 clk = ~clk;

  matrix_scheduler #(.ROW_TICKS(4), .BLANK_TICKS(2), .MIN_HOLD_FRAMES(2)) dut (
    .CLOCK_50(clk), .reset(reset), .req(req),
    .frame0(frame0), .frame1(frame1), .frame2(frame2),
    .grant(grant), .active_id(active_id), .row(row), .column(column),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic [2:0] g;
    logic [1:0] id;
    logic [4:0] r;
    logic [6:0] c;
    logic       fd;
  } obs_t;

  localparam logic [34:0] ONES = 35'h7_FFFF_FFFF;
  localparam logic [34:0] PAT1 = 35'h5_5555_5555;
  localparam logic [34:0] PAT2 = 35'h0_1234_5678;

  obs_t  exp_q[$];
  int    n_checks = 0;
  int    n_err    = 0;
  string scen     = "init";

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic obs_t mk(input logic [2:0] g, input logic [4:0] r,
                              input logic [6:0] c, input logic fd);
    obs_t o;
    o.g  = g;
    o.id = g[2] ? 2'd2 : (g[1] ? 2'd1 : 2'd0);
    o.r  = r;
    o.c  = c;
    o.fd = fd;
    return o;
  endfunction

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(3'b000, 5'b0, 7'b0, 1'b0));
  endtask

  // Frame cycle k (0..29): row k/6, first two cycles of each row blank.
  task automatic push_part(input logic [2:0] g, input logic [34:0] bits,
                           input int from, input int to);
    logic [34:0] b;
    for (int k = from; k < to; k++) begin
      int r, t;
      r = k / 6;
      t = k % 6;
      b = bits >> (r * 7);
      if (t < 2) exp_q.push_back(mk(g, 5'b0, 7'b0, 1'b0));
      else       exp_q.push_back(mk(g, 5'(1 << r), b[6:0], k == 29));
    end
  endtask

  task automatic push_frames(input logic [2:0] g, input logic [34:0] bits, input int n);
    for (int i = 0; i < n; i++) push_part(g, bits, 0, 30);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    obs_t e, o;
    while (exp_q.size() > 0) begin
      cyc();
      e = exp_q.pop_front();
      o = {grant, active_id, row, column, frame_done};
      check(scen, 64'(o), 64'(e));
    end
  endtask

  initial begin
    reset = 1'b1; req = 3'b000;
    frame0 = '0; frame1 = '0; frame2 = '0;

    scen = "reset";
    push_idle(2); drain();
    reset = 1'b0;

    // Single requester, all pixels lit; owner drop on the last lit cycle.
    scen = "single";
    req = 3'b010; frame1 = ONES;
    push_frames(3'b010, ONES, 3); drain();
    req = 3'b000;
    scen = "drop_at_end";
    push_idle(2); drain();

    // Pixel mapping: bit 9 = row 1, column 2. rr_last=1 so requester 0 wins.
    scen = "pixel";
    req = 3'b001; frame0 = 35'h200;
    push_frames(3'b001, 35'h200, 1); drain();
    req = 3'b000;
    push_idle(1); drain();

    scen = "reset2";
    reset = 1'b1; push_idle(1); drain(); reset = 1'b0;

    // Round robin with two-frame hold; distinct pictures per requester.
    scen = "rr";
    frame0 = ONES; frame1 = PAT1; frame2 = PAT2; req = 3'b111;
    push_frames(3'b001, ONES, 2);
    push_frames(3'b010, PAT1, 2);
    push_frames(3'b100, PAT2, 2);
    push_frames(3'b001, ONES, 2);
    drain();
    req = 3'b000;
    push_idle(1); drain();

    // Owner 1 drops while row 2 is lit; then 0 and 2 request.
    scen = "mid_drop";
    frame1 = ONES; req = 3'b010;
    push_part(3'b010, ONES, 0, 16); drain();
    req = 3'b000;
    push_idle(1); drain();
    scen = "after_drop";
    req = 3'b101;
    push_frames(3'b100, PAT2, 1); drain();
    req = 3'b000;
    push_idle(1); drain();

    // Frame input change mid-frame only shows from the next frame; a
    // non-owner request toggling meanwhile must not disturb the owner.
    scen = "tear";
    frame0 = ONES; req = 3'b001;
    push_part(3'b001, ONES, 0, 16); drain();
    frame0 = '0; req = 3'b011;
    push_part(3'b001, ONES, 16, 20); drain();
    req = 3'b001;
    push_part(3'b001, ONES, 20, 30);
    push_frames(3'b001, '0, 1);
    drain();

    // Reset while a row is lit; afterwards requester 0 wins first again.
    scen = "mid_reset";
    push_part(3'b001, '0, 0, 9); drain();
    reset = 1'b1;
    push_idle(1); drain();
    reset = 1'b0; req = 3'b011; frame0 = ONES;
    scen = "post_reset";
    push_frames(3'b001, ONES, 1); drain();
    req = 3'b000;
    push_idle(1); drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
